pc_fetch_unit: RTL and testbench

//  Owns the architectural PC and drives instruction fetch for the 16-bit pipeline.

---
 rtl/pc_fetch_unit_pkg.sv | 23 ++
 rtl/pc_fetch_unit_if.sv | 23 ++
 rtl/pc_fetch_unit_addsub.sv | 17 +
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 tb/tb_pc_fetch_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the 16-bit pipeline front end: fetch FSM encodings,
// HLT opcode, PC step and the ALU flag bit positions used by branch resolution.
package pc_fetch_unit_pkg;

  localparam logic [3:0]  OPC_HLT = 4'hF;
  localparam logic [15:0] PC_STEP = 16'h0002;

  // Flag register bit positions consumed by branch resolution in ID.
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_hlt(input logic [15:0] instr, input logic [3:0] opc);
    return instr[15:12] == opc;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out, ready/read data back.
interface pc_fetch_unit_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_unit_addsub.sv
// Shared 16-bit adder/subtractor; result wraps modulo 2^16 and sat flags
// signed overflow for callers that want to saturate.
module addsub_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] y,
  output logic        sat
);

  logic [15:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign y     = a + b_eff + {15'b0, sub};
  assign sat   = (a[15] == b_eff[15]) && (y[15] != a[15]);

endmodule

// File: rtl/pc_fetch_unit.sv
// Owns the architectural PC: issues word fetches over the imem bus, fills the
// IF/ID slot, applies ID redirects and hazard stalls, and stops on HLT.
module pc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  OPC_HLT  = pc_fetch_unit_pkg::OPC_HLT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [15:0]             redirect_pc,
  pc_fetch_unit_if.master         imem,
  output logic                    if_valid,
  output logic [15:0]             if_instr,
  output logic [15:0]             if_pc_plus2,
  output logic                    flush,
  output logic                    halted
);

  import pc_fetch_unit_pkg::*;

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  pc_inc;
  logic         pc_inc_sat_unused;
  logic         if_valid_q, if_valid_d;
  logic [15:0]  if_instr_q, if_instr_d;
  logic [15:0]  if_pc_plus2_q, if_pc_plus2_d;
  logic         flush_q, flush_d;

  addsub_16bit u_pc_inc (
    .a   (pc_q),
    .b   (PC_STEP),
    .sub (1'b0),
    .y   (pc_inc),
    .sat (pc_inc_sat_unused)
  );

  assign imem.imem_req  = (state_q == ST_FETCH) && !stall;
  assign imem.imem_addr = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instr       = if_instr_q;
  assign if_pc_plus2    = if_pc_plus2_q;
  assign flush          = flush_q;
  assign halted         = (state_q == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 16'h0000;
      if_pc_plus2_q <= RESET_PC;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_plus2_q <= if_pc_plus2_d;
      flush_q       <= flush_d;
    end
  end

  // Redirect beats stall beats completion; a redirect also revives a halted front end.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_plus2_d = if_pc_plus2_q;
    flush_d       = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH, ST_HALTED: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
          flush_d    = 1'b1;
          state_d    = ST_FETCH;
        end else if (stall) begin
          state_d = state_q;
        end else if (state_q == ST_FETCH) begin
          if (imem.imem_ready) begin
            if_valid_d    = 1'b1;
            if_instr_d    = imem.imem_rdata;
            if_pc_plus2_d = pc_inc;
            pc_d          = pc_inc;
            if (is_hlt(imem.imem_rdata, OPC_HLT)) begin
              state_d = ST_HALTED;
            end
          end else begin
            if_valid_d = 1'b0;
          end
        end else begin
          if_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch/wait/stall/redirect/HLT
// sequence on one instance and PC wrap plus async reset on a second instance.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst1_n, rst2_n;
  logic        stall1, stall2;
  logic        redir1, redir2;
  logic [15:0] rpc1, rpc2;
  logic        if_valid1, if_valid2;
  logic [15:0] if_instr1, if_instr2;
  logic [15:0] if_pc21, if_pc22;
  logic        flush1, flush2;
  logic        halted1, halted2;
  logic        stall_seen1, stall_seen2;

  int total = 0;
  int bad   = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  pc_fetch_unit_if bus1();
  pc_fetch_unit_if bus2();

  always #5 clk = ~clk;

  // Instruction memory image: HLT at 0x0010, everything else tagged with its address.
  function automatic logic [15:0] imem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hF000;
    return {4'hA, a[11:0]};
  endfunction

  assign bus1.imem_rdata = imem_word(bus1.imem_addr);
  assign bus2.imem_rdata = imem_word(bus2.imem_addr);

  pc_fetch_unit #(.RESET_PC(16'h0000)) dut1 (
    .clk(clk), .rst_n(rst1_n), .stall(stall1), .redirect_valid(redir1),
    .redirect_pc(rpc1), .imem(bus1), .if_valid(if_valid1), .if_instr(if_instr1),
    .if_pc_plus2(if_pc21), .flush(flush1), .halted(halted1)
  );

  pc_fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst_n(rst2_n), .stall(stall2), .redirect_valid(redir2),
    .redirect_pc(rpc2), .imem(bus2), .if_valid(if_valid2), .if_instr(if_instr2),
    .if_pc_plus2(if_pc22), .flush(flush2), .halted(halted2)
  );

  always @(posedge clk) begin
    stall_seen1 <= stall1;
    stall_seen2 <= stall2;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A slot loaded at the last edge (not held by stall) is a new delivery to ID.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst1_n === 1'b1 && if_valid1 === 1'b1 && stall_seen1 === 1'b0) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL dut1_extra: got %h/%h, expected nothing", if_instr1, if_pc21);
      end else begin
        e = q1.pop_front();
        checkOutput("dut1_instr", if_instr1, e[31:16]);
        checkOutput("dut1_pc2", if_pc21, e[15:0]);
      end
    end
    if (rst2_n === 1'b1 && if_valid2 === 1'b1 && stall_seen2 === 1'b0) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL dut2_extra: got %h/%h, expected nothing", if_instr2, if_pc22);
      end else begin
        e = q2.pop_front();
        checkOutput("dut2_instr", if_instr2, e[31:16]);
        checkOutput("dut2_pc2", if_pc22, e[15:0]);
      end
    end
  end

  initial begin
    rst1_n = 1'b1; rst2_n = 1'b1;
    stall1 = 1'b0; stall2 = 1'b0;
    redir1 = 1'b0; redir2 = 1'b0;
    rpc1 = 16'h0; rpc2 = 16'h0;
    bus1.imem_ready = 1'b1;
    bus2.imem_ready = 1'b1;

    q1.push_back({16'hA000, 16'h0002});
    q1.push_back({16'hA002, 16'h0004});
    q1.push_back({16'hA004, 16'h0006});
    q1.push_back({16'hA006, 16'h0008});
    q1.push_back({16'hA008, 16'h000A});
    q1.push_back({16'hA040, 16'h0042});
    q1.push_back({16'hA00E, 16'h0010});
    q1.push_back({16'hF000, 16'h0012});
    q1.push_back({16'hA020, 16'h0022});
    q2.push_back({16'hAFFE, 16'h0000});

    #1 rst1_n = 1'b0; rst2_n = 1'b0;
    #2;
    checkOutput("rst_valid", {15'b0, if_valid1}, 16'h0000);
    checkOutput("rst_instr", if_instr1, 16'h0000);
    checkOutput("rst_pc2", if_pc21, 16'h0000);
    checkOutput("rst_req", {15'b0, bus1.imem_req}, 16'h0000);
    checkOutput("rst_addr", bus1.imem_addr, 16'h0000);
    checkOutput("rst_flush", {15'b0, flush1}, 16'h0000);
    checkOutput("rst_halted", {15'b0, halted1}, 16'h0000);

    // Straight-line fetch with a zero-wait memory.
    applyStimulus(1); rst1_n = 1'b1;
    checkOutput("boot_req", {15'b0, bus1.imem_req}, 16'h0000);
    applyStimulus(1);
    checkOutput("f0_req", {15'b0, bus1.imem_req}, 16'h0001);
    checkOutput("f0_addr", bus1.imem_addr, 16'h0000);
    applyStimulus(1);
    checkOutput("f1_addr", bus1.imem_addr, 16'h0002);
    applyStimulus(1);
    checkOutput("f2_addr", bus1.imem_addr, 16'h0004);
    bus1.imem_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput("wait_addr", bus1.imem_addr, 16'h0004);
      checkOutput("wait_valid", {15'b0, if_valid1}, 16'h0000);
      checkOutput("wait_req", {15'b0, bus1.imem_req}, 16'h0001);
    end
    bus1.imem_ready = 1'b1;
    applyStimulus(1);
    checkOutput("post_wait_addr", bus1.imem_addr, 16'h0006);
    applyStimulus(1);
    checkOutput("pre_stall_addr", bus1.imem_addr, 16'h0008);
    stall1 = 1'b1;

    for (int i = 0; i < 2; i++) begin
      applyStimulus(1);
      checkOutput("stall_req", {15'b0, bus1.imem_req}, 16'h0000);
      checkOutput("stall_instr", if_instr1, 16'hA006);
      checkOutput("stall_pc2", if_pc21, 16'h0008);
      checkOutput("stall_addr", bus1.imem_addr, 16'h0008);
    end
    stall1 = 1'b0;
    applyStimulus(1);
    checkOutput("resume_addr", bus1.imem_addr, 16'h000A);
    redir1 = 1'b1; rpc1 = 16'h0040;

    // Redirect collides with the completion at 000A, then back-to-back redirect.
    applyStimulus(1);
    checkOutput("redir_flush", {15'b0, flush1}, 16'h0001);
    checkOutput("redir_valid", {15'b0, if_valid1}, 16'h0000);
    checkOutput("redir_addr", bus1.imem_addr, 16'h0040);
    redir1 = 1'b0;
    applyStimulus(1);
    checkOutput("flush_drop", {15'b0, flush1}, 16'h0000);
    checkOutput("tgt_next_addr", bus1.imem_addr, 16'h0042);
    redir1 = 1'b1; rpc1 = 16'h000E;
    applyStimulus(1);
    checkOutput("redir2_flush", {15'b0, flush1}, 16'h0001);
    checkOutput("redir2_addr", bus1.imem_addr, 16'h000E);
    redir1 = 1'b0;
    applyStimulus(1);
    checkOutput("flush2_drop", {15'b0, flush1}, 16'h0000);
    checkOutput("hlt_addr", bus1.imem_addr, 16'h0010);

    // HLT delivered once, then front end idles until redirected.
    applyStimulus(1);
    checkOutput("hlt_halted", {15'b0, halted1}, 16'h0001);
    checkOutput("hlt_req", {15'b0, bus1.imem_req}, 16'h0000);
    applyStimulus(1);
    checkOutput("halt_halted", {15'b0, halted1}, 16'h0001);
    checkOutput("halt_valid", {15'b0, if_valid1}, 16'h0000);
    checkOutput("halt_addr", bus1.imem_addr, 16'h0012);
    redir1 = 1'b1; rpc1 = 16'h0020;
    applyStimulus(1);
    checkOutput("wake_halted", {15'b0, halted1}, 16'h0000);
    checkOutput("wake_flush", {15'b0, flush1}, 16'h0001);
    checkOutput("wake_addr", bus1.imem_addr, 16'h0020);
    checkOutput("wake_req", {15'b0, bus1.imem_req}, 16'h0001);
    redir1 = 1'b0;
    applyStimulus(1);
    checkOutput("wake_next_addr", bus1.imem_addr, 16'h0022);
    stall1 = 1'b1;
    applyStimulus(2);

    // PC wrap from FFFE, then async reset while waiting on memory.
    rst2_n = 1'b1;
    checkOutput("w_boot_req", {15'b0, bus2.imem_req}, 16'h0000);
    applyStimulus(1);
    checkOutput("w_addr0", bus2.imem_addr, 16'hFFFE);
    checkOutput("w_req0", {15'b0, bus2.imem_req}, 16'h0001);
    applyStimulus(1);
    checkOutput("w_wrap_addr", bus2.imem_addr, 16'h0000);
    bus2.imem_ready = 1'b0;
    applyStimulus(1);
    checkOutput("w_wait_valid", {15'b0, if_valid2}, 16'h0000);
    checkOutput("w_wait_addr", bus2.imem_addr, 16'h0000);
    #2 rst2_n = 1'b0;
    #1;
    checkOutput("ar_valid", {15'b0, if_valid2}, 16'h0000);
    checkOutput("ar_instr", if_instr2, 16'h0000);
    checkOutput("ar_pc2", if_pc22, 16'hFFFE);
    checkOutput("ar_addr", bus2.imem_addr, 16'hFFFE);
    checkOutput("ar_req", {15'b0, bus2.imem_req}, 16'h0000);
    checkOutput("ar_flush", {15'b0, flush2}, 16'h0000);
    checkOutput("ar_halted", {15'b0, halted2}, 16'h0000);
    applyStimulus(2);

    checkOutput("q1_drained", q1.size()[15:0], 16'h0000);
    checkOutput("q2_drained", q2.size()[15:0], 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
